ysyx_25020047_dmem_resp: RTL and testbench

- Data-memory responder on the far end of the execute unit's load/store interface.
- Accepts one load or store request at a time: byte address computed by EXU, access size, signedness, and store data.
- Performs the access on an internal word-organised SRAM array after a programmable latency.
- Returns an aligned, sign- or zero-extended load result, or an error flag, to write-back over a valid/ready handshake.

---
 rtl/ysyx_25020047_dmem_resp.sv | 138 +++++++++++++
 tb/tb_ysyx_25020047_dmem_resp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_dmem_resp.sv
// ysyx_25020047_dmem_resp: load/store responder that serves one request at a time
// on a word-organised SRAM, answering after a fixed latency over valid/ready.
`default_nettype none

module ysyx_25020047_dmem_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write, cap_unsigned;
  logic [1:0]  cap_size;
  logic [3:0]  cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, execute, err;
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic [31:0] word_rd, shifted, load_data, wlanes, merged;
  logic [15:0] half_rd;
  logic [3:0]  be;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign execute   = (state == BUSY) && (cnt == 4'd0);

  // ADDR_BASE is word aligned, so the word offset alone decides range and index.
  assign word_off = cap_addr[31:2] - ADDR_BASE[31:2];
  assign idx      = word_off[AW-1:0];
  assign err      = (cap_size == 2'd3)
                  | ((cap_size == 2'd1) & cap_addr[0])
                  | ((cap_size == 2'd2) & (|cap_addr[1:0]))
                  | (|word_off[29:AW]);

  assign word_rd = mem[idx];
  assign shifted = word_rd >> {cap_addr[1:0], 3'b000};
  assign half_rd = cap_addr[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    load_data = word_rd;
    wlanes    = cap_wdata;
    be        = 4'b1111;
    case (cap_size)
      2'd0: begin
        load_data = cap_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        wlanes    = {4{cap_wdata[7:0]}};
        be        = 4'b0001 << cap_addr[1:0];
      end
      2'd1: begin
        load_data = cap_unsigned ? {16'd0, half_rd} : {{16{half_rd[15]}}, half_rd};
        wlanes    = {2{cap_wdata[15:0]}};
        be        = cap_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : word_rd[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
      cap_write    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'd0;
      cnt          <= 4'd0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr     <= req_addr;
        cap_wdata    <= req_wdata;
        cap_write    <= req_write;
        cap_unsigned <= req_unsigned;
        cap_size     <= req_size;
        cnt          <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (execute) begin
        rsp_err   <= err;
        rsp_rdata <= (err | cap_write) ? 32'd0 : load_data;
      end
    end
  end

  // Array is not reset; execute is already false while rst_n is low.
  always_ff @(posedge clk) begin
    if (execute && cap_write && !err) mem[idx] <= merged;
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_dmem_resp.sv
// tb_ysyx_25020047_dmem_resp: directed self-checking bench for the data-memory responder.
`default_nettype none

module tb_ysyx_25020047_dmem_resp;
  localparam int LAT = 3;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  ysyx_25020047_dmem_resp #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Issue one request and complete its response handshake; returns observations only.
  task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat, output logic [1:0] post);
    req_addr = a; req_write = w; req_size = sz; req_unsigned = u; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; e = rsp_err; post = 2'b11;
    if (rsp_valid) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      post = {rsp_valid, req_ready};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL idle_rsp_ready got %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat; logic [1:0] post;
    xact(32'h8000_0010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, e, lat, post);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sw_latency got %0d want %0d", lat, LAT); end
    checks++; if ({e, rd} !== 33'd0) begin errors++; $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", e, rd); end
    checks++; if (post !== 2'b01) begin errors++; $display("FAIL sw_post got %b want 01", post); end
    xact(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL lw_latency got %0d want %0d", lat, LAT); end
    checks++; if ({e, rd} !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL lw_word got err=%b rdata=%h want 0/deadbeef", e, rd); end
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic e; int lat; logic [1:0] post;
    logic [31:0] ea [5] = '{32'h8000_0021, 32'h8000_0020, 32'h8000_0020, 32'h8000_0022, 32'h8000_0022};
    logic [1:0]  es [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        eu [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex [5] = '{32'h0000_007F, 32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_80F1};
    xact(32'h8000_0020, 1'b1, 2'd2, 1'b0, 32'h80F1_7F82, rd, e, lat, post);
    for (int i = 0; i < 5; i++) begin
      xact(ea[i], 1'b0, es[i], eu[i], 32'd0, rd, e, lat, post);
      checks++;
      if ({e, rd} !== {1'b0, ex[i]}) begin
        errors++; $display("FAIL ext_%0d got err=%b rdata=%h want 0/%h", i, e, rd, ex[i]);
      end
    end
  endtask

  task automatic test_merge();
    logic [31:0] rd; logic e; int lat; logic [1:0] post;
    xact(32'h8000_0030, 1'b1, 2'd2, 1'b0, 32'h1122_3344, rd, e, lat, post);
    xact(32'h8000_0031, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFAA, rd, e, lat, post);
    checks++; if ({e, rd} !== 33'd0) begin errors++; $display("FAIL sb_rsp got err=%b rdata=%h want 0/0", e, rd); end
    xact(32'h8000_0032, 1'b1, 2'd1, 1'b0, 32'h1234_BEEF, rd, e, lat, post);
    xact(32'h8000_0030, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'hBEEF_AA44}) begin errors++; $display("FAIL merge_word got err=%b rdata=%h want 0/beefaa44", e, rd); end
    xact(32'h8000_0033, 1'b0, 2'd0, 1'b1, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'h0000_00BE}) begin errors++; $display("FAIL merge_lbu got err=%b rdata=%h want 0/000000be", e, rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat; logic [1:0] post;
    xact(32'h8000_0002, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL lw_misaligned got err=%b rdata=%h want 1/0", e, rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL err_latency got %0d want %0d", lat, LAT); end
    xact(32'h8000_0040, 1'b1, 2'd2, 1'b0, 32'h1234_5678, rd, e, lat, post);
    xact(32'h8000_0041, 1'b1, 2'd1, 1'b0, 32'h0000_FFFF, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL sh_misaligned got err=%b rdata=%h want 1/0", e, rd); end
    xact(32'h8000_0040, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL sh_no_write got err=%b rdata=%h want 0/12345678", e, rd); end
    xact(32'h7FFF_FFFC, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL below_base got err=%b rdata=%h want 1/0", e, rd); end
    xact(32'h8000_1000, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL past_end got err=%b rdata=%h want 1/0", e, rd); end
    xact(32'h8000_0FFC, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, rd, e, lat, post);
    xact(32'h8000_0FFC, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL last_word got err=%b rdata=%h want 0/cafef00d", e, rd); end
    xact(32'h8000_0010, 1'b0, 2'd3, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL size3 got err=%b rdata=%h want 1/0", e, rd); end
  endtask

  task automatic test_backpressure();
    int n;
    req_addr = 32'h8000_0010; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", n, LAT); end
    // A competing request during RESP must be ignored.
    req_addr = 32'h8000_0020; req_write = 1'b1; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b rdy=%b err=%b rdata=%h want 1/0/0/deadbeef",
                           i, rsp_valid, req_ready, rsp_err, rsp_rdata);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat; logic [1:0] post;
    xact(32'h8000_0020, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'h80F1_7F82}) begin errors++; $display("FAIL b2b_first got err=%b rdata=%h want 0/80f17f82", e, rd); end
    xact(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if (lat !== LAT || post !== 2'b01) begin errors++; $display("FAIL b2b_second got lat=%0d post=%b want %0d/01", lat, post, LAT); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic e; int lat; logic [1:0] post; int n;
    xact(32'h8000_0050, 1'b1, 2'd2, 1'b0, 32'h0000_0000, rd, e, lat, post);
    req_addr = 32'h8000_0050; req_write = 1'b1; req_size = 2'd2; req_wdata = 32'h5555_5555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_valid got %b want 0", rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_idle got req_ready=%b want 1", req_ready); end
    // Reset during RESP: the store has already committed.
    req_addr = 32'h8000_0060; req_write = 1'b1; req_size = 2'd2; req_wdata = 32'h0000_0077; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_reach got v=%b want 1", rsp_valid); end
    #2 rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_async got v=%b want 0", rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    xact(32'h8000_0050, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== 33'd0) begin errors++; $display("FAIL rst_discard got err=%b rdata=%h want 0/0", e, rd); end
    xact(32'h8000_0060, 1'b0, 2'd2, 1'b0, 32'd0, rd, e, lat, post);
    checks++; if ({e, rd} !== {1'b0, 32'h0000_0077}) begin errors++; $display("FAIL rst_kept got err=%b rdata=%h want 0/00000077", e, rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_merge();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
